// File: rtl/int_rename_pkg.sv
// int_rename_pkg: shared widths, tag/pointer types and helpers for the integer rename free lists.
package int_rename_pkg;
    localparam int TAG_W = 6;
    localparam int DEPTH = 32;
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int ALLOC_N = 2;
    localparam int FREE_N = 2;
    typedef logic [TAG_W-1:0] phys_tag_t;
    typedef logic [PTR_W-1:0] fl_ptr_t;
    function automatic logic [2:0] popcount(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction
endpackage

// File: rtl/fl_free_compact.sv
// fl_free_compact: packs valid released tags into ascending slots and counts them.
module fl_free_compact import int_rename_pkg::*; #(
    parameter int TAG_W = int_rename_pkg::TAG_W,
    parameter int FREE_N = int_rename_pkg::FREE_N,
    localparam int CNT_W = $clog2(FREE_N + 1)
) (
    input  logic [FREE_N-1:0]       free_vld,
    input  logic [FREE_N*TAG_W-1:0] free_tag,
    output logic [FREE_N*TAG_W-1:0] cmp_tag,
    output logic [CNT_W-1:0]        wr_cnt
);
    always_comb begin
        cmp_tag = '0;
        wr_cnt = '0;
        for (int i = 0; i < FREE_N; i++)
            if (free_vld[i]) begin
                cmp_tag[int'(wr_cnt)*TAG_W +: TAG_W] = free_tag[i*TAG_W +: TAG_W];
                wr_cnt = wr_cnt + CNT_W'(1);
            end
    end
endmodule

// File: rtl/int_free_list_mp.sv
// int_free_list_mp: multi-port circular free list of physical tags with a committed head
// so a flush can rewind the speculative head in one cycle.
module int_free_list_mp import int_rename_pkg::*; #(
    parameter int TAG_W = int_rename_pkg::TAG_W,
    parameter int DEPTH = int_rename_pkg::DEPTH,
    parameter int ALLOC_N = int_rename_pkg::ALLOC_N,
    parameter int FREE_N = int_rename_pkg::FREE_N,
    parameter int INIT_BASE = 32,
    parameter int INIT_STRIDE = 1,
    parameter int INIT_COUNT = 32,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1,
    localparam int CN_W = $clog2(ALLOC_N + 1),
    localparam int WC_W = $clog2(FREE_N + 1)
) (
    input  logic                     Clk,
    input  logic                     Rest,
    input  logic [ALLOC_N-1:0]       AllocReq,
    output logic [ALLOC_N*TAG_W-1:0] AllocTag,
    output logic                     AllocOk,
    input  logic [FREE_N-1:0]        FreeVld,
    input  logic [FREE_N*TAG_W-1:0]  FreeTag,
    input  logic [CN_W-1:0]          CommitNum,
    input  logic                     Flush,
    output logic [PTR_W-1:0]         FreeCount,
    output logic                     Empty,
    output logic                     Full
);
    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] spec_head, commit_head, tail;
    logic [FREE_N*TAG_W-1:0] cmp_tag;
    logic [WC_W-1:0] wr_cnt;
    logic [2:0] k;

    assign k = popcount(4'(AllocReq));
    assign FreeCount = tail - spec_head;
    assign Empty = FreeCount == '0;
    assign Full = FreeCount == PTR_W'(DEPTH);
    assign AllocOk = FreeCount >= PTR_W'(k);

    for (genvar i = 0; i < ALLOC_N; i++) begin : g_peek
        assign AllocTag[i*TAG_W +: TAG_W] = mem[spec_head[IDX_W-1:0] + IDX_W'(i)];
    end

    fl_free_compact #(.TAG_W(TAG_W), .FREE_N(FREE_N)) u_compact (
        .free_vld(FreeVld),
        .free_tag(FreeTag),
        .cmp_tag (cmp_tag),
        .wr_cnt  (wr_cnt)
    );

    // Flush rewinds to the committed head; contents there are still intact.
    always_ff @(posedge Clk or negedge Rest)
        if (!Rest) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= (i < INIT_COUNT) ? TAG_W'(INIT_BASE + i * INIT_STRIDE) : '0;
            spec_head <= '0;
            commit_head <= '0;
            tail <= PTR_W'(INIT_COUNT);
        end else begin
            for (int i = 0; i < FREE_N; i++)
                if (i < int'(wr_cnt))
                    mem[tail[IDX_W-1:0] + IDX_W'(i)] <= cmp_tag[i*TAG_W +: TAG_W];
            commit_head <= commit_head + PTR_W'(CommitNum);
            tail <= tail + PTR_W'(wr_cnt);
            spec_head <= Flush ? commit_head + PTR_W'(CommitNum) :
                         AllocOk ? spec_head + PTR_W'(k) : spec_head;
        end

    always @(posedge Clk)
        if (Rest) begin
            assert ((AllocReq & (AllocReq + ALLOC_N'(1))) == '0);
            assert (int'(FreeCount) + int'(wr_cnt) <= DEPTH);
            assert (PTR_W'(spec_head - commit_head) >= PTR_W'(CommitNum));
            assert (int'(CommitNum) <= ALLOC_N);
        end
endmodule
